// File: rtl/parking_slot_manager.sv
// parking_slot_manager: controller for a 4-spot parking lot.
// It owns the occupancy register that feeds the first-free-spot encoder and
// consumes the encoder's location code. It services entry and exit requests
// and drives the gate. All outputs are registered.
//
// Handshake: enter_req / exit_req are level requests held by the requester
// until the matching 1-cycle ack pulse. After an ack the FSM parks in RELEASE
// until both requests are low, so a request still held after its ack is
// never serviced a second time.
module parking_slot_manager #(
  parameter int          GATE_CYCLES = 8,
  parameter logic [2:0]  FULL_CODE   = 3'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic [2:0] loc_code,
  output logic [3:0] occupancy,
  output logic       enter_ack,
  output logic       exit_ack,
  output logic       grant_valid,
  output logic [1:0] grant_slot,
  output logic       reject,
  output logic       exit_err,
  output logic       code_err,
  output logic       gate_open,
  output logic [2:0] free_count,
  output logic       full,
  output logic [7:0] entry_total,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    EXIT    = 3'd2,
    GATE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] occ_nxt;
  logic [1:0] gs_nxt;
  logic       eack_nxt, xack_nxt, gv_nxt, rej_nxt, xerr_nxt, cerr_nxt, gate_nxt;
  logic [7:0] tot_nxt;
  logic [2:0] fc_nxt;

  assign fsm_state = state;

  // Next-state and next-output logic; everything defaults to hold / no pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    occ_nxt   = occupancy;
    gs_nxt    = grant_slot;
    tot_nxt   = entry_total;
    cerr_nxt  = code_err;
    gate_nxt  = gate_open;
    eack_nxt  = 1'b0;
    xack_nxt  = 1'b0;
    gv_nxt    = 1'b0;
    rej_nxt   = 1'b0;
    xerr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Exit wins when both requests are present.
        if (exit_req)       state_nxt = EXIT;
        else if (enter_req) state_nxt = CHECK;
      end
      CHECK: begin
        eack_nxt = 1'b1;
        if (loc_code[2] == 1'b0) begin
          occ_nxt[loc_code[1:0]] = 1'b1;
          gs_nxt    = loc_code[1:0];
          gv_nxt    = 1'b1;
          tot_nxt   = entry_total + 8'd1;
          cnt_nxt   = 8'(GATE_CYCLES);
          gate_nxt  = 1'b1;
          state_nxt = GATE;
        end else begin
          // Full lot or an illegal encoder code: refuse the car either way.
          rej_nxt = 1'b1;
          if (loc_code != FULL_CODE) cerr_nxt = 1'b1;
          state_nxt = RELEASE;
        end
      end
      EXIT: begin
        xack_nxt = 1'b1;
        if (occupancy[exit_slot]) begin
          occ_nxt[exit_slot] = 1'b0;
          cnt_nxt   = 8'(GATE_CYCLES);
          gate_nxt  = 1'b1;
          state_nxt = GATE;
        end else begin
          xerr_nxt  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      GATE: begin
        // Counter was loaded with GATE_CYCLES together with gate_open=1, so
        // closing when it reads 1 keeps the gate open exactly GATE_CYCLES.
        if (cnt <= 8'd1) begin
          gate_nxt  = 1'b0;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RELEASE: begin
        if (!enter_req && !exit_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Free-spot count of the next occupancy so it updates with occupancy.
  always_comb begin
    fc_nxt = 3'd0;
    for (int i = 0; i < 4; i++) fc_nxt = fc_nxt + {2'b00, ~occ_nxt[i]};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      occupancy   <= 4'd0;
      grant_slot  <= 2'd0;
      entry_total <= 8'd0;
      code_err    <= 1'b0;
      gate_open   <= 1'b0;
      enter_ack   <= 1'b0;
      exit_ack    <= 1'b0;
      grant_valid <= 1'b0;
      reject      <= 1'b0;
      exit_err    <= 1'b0;
      free_count  <= 3'd4;
      full        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      occupancy   <= occ_nxt;
      grant_slot  <= gs_nxt;
      entry_total <= tot_nxt;
      code_err    <= cerr_nxt;
      gate_open   <= gate_nxt;
      enter_ack   <= eack_nxt;
      exit_ack    <= xack_nxt;
      grant_valid <= gv_nxt;
      reject      <= rej_nxt;
      exit_err    <= xerr_nxt;
      free_count  <= fc_nxt;
      full        <= &occ_nxt;
    end
  end

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed testbench for parking_slot_manager with a behavioural
// first-free-spot encoder closing the loop on occupancy.
module tb_parking_slot_manager;

  localparam logic [2:0] S_IDLE = 3'd0, S_GATE = 3'd3, S_RELEASE = 3'd4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enter_req = 1'b0, exit_req = 1'b0;
  logic [1:0] exit_slot = 2'd0;
  logic [2:0] loc_code;
  logic [3:0] occupancy;
  logic       enter_ack, exit_ack, grant_valid, reject, exit_err, code_err;
  logic       gate_open, full;
  logic [1:0] grant_slot;
  logic [2:0] free_count, fsm_state;
  logic [7:0] entry_total;
  logic       force_code = 1'b0;

  int checks = 0;
  int errors = 0;

  parking_slot_manager #(.GATE_CYCLES(8), .FULL_CODE(3'd5)) dut (
    .clk(clk), .rst_n(rst_n), .enter_req(enter_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .loc_code(loc_code), .occupancy(occupancy),
    .enter_ack(enter_ack), .exit_ack(exit_ack), .grant_valid(grant_valid),
    .grant_slot(grant_slot), .reject(reject), .exit_err(exit_err),
    .code_err(code_err), .gate_open(gate_open), .free_count(free_count),
    .full(full), .entry_total(entry_total), .fsm_state(fsm_state)
  );

  // Encoder model: first free spot, 5 when full, 6 when forced illegal.
  always_comb begin
    if (force_code)         loc_code = 3'd6;
    else if (!occupancy[0]) loc_code = 3'd0;
    else if (!occupancy[1]) loc_code = 3'd1;
    else if (!occupancy[2]) loc_code = 3'd2;
    else if (!occupancy[3]) loc_code = 3'd3;
    else                    loc_code = 3'd5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Count negedges with gate_open high, bounded.
  task automatic count_gate(input int exp_cycles);
    int g = 0;
    while (gate_open && g < 300) begin
      g++;
      @(negedge clk);
    end
    check("gate_cycles", g, exp_cycles);
  endtask

  // Hold the request one more cycle in RELEASE, then drop and expect IDLE.
  task automatic release_reqs;
    @(negedge clk);
    check("hold_release", fsm_state, S_RELEASE);
    enter_req = 1'b0;
    exit_req  = 1'b0;
    @(negedge clk);
    check("back_idle", fsm_state, S_IDLE);
  endtask

  task automatic enter_car(input logic exp_grant, input logic [1:0] exp_slot, input int exp_gate);
    int n = 0;
    enter_req = 1'b1;
    @(negedge clk);
    while (!enter_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("enter_ack", enter_ack, 1);
    check("enter_latency", n, 1);
    check("grant_valid", grant_valid, exp_grant);
    check("reject", reject, !exp_grant);
    if (exp_grant) check("grant_slot", grant_slot, exp_slot);
    count_gate(exp_gate);
    release_reqs();
  endtask

  task automatic exit_car(input logic [1:0] slot, input logic exp_err, input int exp_gate);
    int n = 0;
    exit_slot = slot;
    exit_req  = 1'b1;
    @(negedge clk);
    while (!exit_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("exit_ack", exit_ack, 1);
    check("exit_err", exit_err, exp_err);
    count_gate(exp_gate);
    release_reqs();
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_occ", occupancy, 0);
    check("rst_free", free_count, 4);
    check("rst_full", full, 0);
    check("rst_gate", gate_open, 0);
    check("rst_slot", grant_slot, 0);
    check("rst_total", entry_total, 0);
    check("rst_cerr", code_err, 0);
    check("rst_acks", {enter_ack, exit_ack, grant_valid, reject, exit_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state", fsm_state, S_IDLE);

    // First entry
    enter_car(1'b1, 2'd0, 8);
    check("occ_0001", occupancy, 4'b0001);
    check("free_3", free_count, 3);
    check("total_1", entry_total, 1);

    // Fill the lot, then a fifth car is rejected
    enter_car(1'b1, 2'd1, 8);
    enter_car(1'b1, 2'd2, 8);
    enter_car(1'b1, 2'd3, 8);
    check("occ_1111", occupancy, 4'b1111);
    check("full_1", full, 1);
    check("free_0", free_count, 0);
    enter_car(1'b0, 2'd0, 0);
    check("occ_unchanged", occupancy, 4'b1111);
    check("total_4", entry_total, 4);
    check("cerr_after_full", code_err, 0);

    // Exit spot 2, next entry reuses it
    exit_car(2'd2, 1'b0, 8);
    check("occ_1011", occupancy, 4'b1011);
    check("free_1", free_count, 1);
    check("full_0", full, 0);
    enter_car(1'b1, 2'd2, 8);

    // Back to 0001, then simultaneous requests: exit wins
    exit_car(2'd1, 1'b0, 8);
    exit_car(2'd2, 1'b0, 8);
    exit_car(2'd3, 1'b0, 8);
    check("occ_0001_b", occupancy, 4'b0001);
    exit_slot = 2'd0;
    exit_req  = 1'b1;
    enter_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!exit_ack && !enter_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("both_exit_ack", exit_ack, 1);
    check("both_no_enter_ack", enter_ack, 0);
    check("both_occ", occupancy, 4'b0000);
    count_gate(8);
    release_reqs();
    enter_car(1'b1, 2'd0, 8);
    check("both_occ_after", occupancy, 4'b0001);

    // Exit from an empty spot
    exit_car(2'd3, 1'b1, 0);
    check("err_occ", occupancy, 4'b0001);

    // Illegal encoder code
    force_code = 1'b1;
    enter_car(1'b0, 2'd0, 0);
    check("cerr_set", code_err, 1);
    check("cerr_occ", occupancy, 4'b0001);
    force_code = 1'b0;
    enter_car(1'b1, 2'd1, 8);
    check("cerr_sticky", code_err, 1);

    // Fresh reset, 256 grants, reset mid-gate
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_cerr", code_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 255; i++) begin
      enter_car(1'b1, 2'd0, 8);
      exit_car(2'd0, 1'b0, 8);
    end
    check("total_255", entry_total, 255);
    enter_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!enter_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wrap_total", entry_total, 0);
    @(negedge clk);
    @(negedge clk);
    check("mid_gate_state", fsm_state, S_GATE);
    check("mid_gate_open", gate_open, 1);
    rst_n = 1'b0;
    #1;
    check("rst_gate_drop", gate_open, 0);
    check("rst_occ_clear", occupancy, 0);
    check("rst_total_0", entry_total, 0);
    enter_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_total", entry_total, 0);
    check("post_rst_state", fsm_state, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
